// File: rtl/div_sqrt_arbiter_mvp_pkg.sv
// Shared definitions for the div/sqrt arbiter: widths, FSM states, request
// struct and the canonical quiet-NaN table used for aborted operations.
package defs_div_sqrt_mvp;

  localparam int C_OP_FP64 = 64;
  localparam int C_RM      = 3;
  localparam int C_FS      = 2;
  localparam int C_FFLAGS  = 5;

  localparam logic [C_OP_FP64-1:0] C_QNAN_FP32    = 64'h0000_0000_7FC0_0000;
  localparam logic [C_OP_FP64-1:0] C_QNAN_FP64    = 64'h7FF8_0000_0000_0000;
  localparam logic [C_OP_FP64-1:0] C_QNAN_FP16    = 64'h0000_0000_0000_7E00;
  localparam logic [C_OP_FP64-1:0] C_QNAN_FP16ALT = 64'h0000_0000_0000_7FC0;
  localparam logic [C_FFLAGS-1:0]  C_TIMEOUT_FLAGS = 5'b10000;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_e;

  typedef struct packed {
    logic                 sqrt;
    logic [C_OP_FP64-1:0] op_a;
    logic [C_OP_FP64-1:0] op_b;
    logic [C_RM-1:0]      rm;
    logic [C_FS-1:0]      fmt;
  } arb_req_t;

  function automatic logic [C_OP_FP64-1:0] canon_nan(input logic [C_FS-1:0] fmt);
    case (fmt)
      2'b00:   canon_nan = C_QNAN_FP32;
      2'b01:   canon_nan = C_QNAN_FP64;
      2'b10:   canon_nan = C_QNAN_FP16;
      default: canon_nan = C_QNAN_FP16ALT;
    endcase
  endfunction

endpackage

// File: rtl/div_sqrt_arbiter_mvp_rr.sv
// Round-robin first-one search: lowest set valid at or above the pointer,
// wrapping modulo NUM_REQ. Purely combinational; the pointer lives upstream.
module rr_arbiter_mvp #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] Valid_SI,
  input  logic [IDX_W-1:0]   Ptr_DI,
  output logic [NUM_REQ-1:0] Gnt_SO,
  output logic [IDX_W-1:0]   Idx_DO,
  output logic               Any_SO
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    Gnt_SO = '0;
    Idx_DO = '0;
    Any_SO = 1'b0;
    pos    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(Ptr_DI) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (Valid_SI[pos[IDX_W-1:0]]) begin
        Any_SO = 1'b1;
        Idx_DO = pos[IDX_W-1:0];
        Gnt_SO = '0;
        Gnt_SO[pos[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_sqrt_arbiter_mvp.sv
// Shares one div/sqrt unit among NUM_REQ requesters, round-robin, one op in
// flight. Optional busy-timeout abort is enabled by DIV_SQRT_ARB_TIMEOUT_EN.
module div_sqrt_arbiter_mvp
  import defs_div_sqrt_mvp::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 127
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RI,
  input  logic [NUM_REQ-1:0]             Req_valid_SI,
  output logic [NUM_REQ-1:0]             Req_ready_SO,
  input  logic [NUM_REQ-1:0]             Req_sqrt_SI,
  input  logic [NUM_REQ*C_OP_FP64-1:0]   Req_operand_a_DI,
  input  logic [NUM_REQ*C_OP_FP64-1:0]   Req_operand_b_DI,
  input  logic [NUM_REQ*C_RM-1:0]        Req_rm_SI,
  input  logic [NUM_REQ*C_FS-1:0]        Req_fmt_SI,
  output logic [NUM_REQ-1:0]             Resp_valid_SO,
  input  logic [NUM_REQ-1:0]             Resp_ready_SI,
  output logic [C_OP_FP64-1:0]           Resp_result_DO,
  output logic [C_FFLAGS-1:0]            Resp_fflags_DO,
  output logic                           Resp_timeout_SO,
  output logic                           Div_start_SO,
  output logic                           Sqrt_start_SO,
  output logic [C_OP_FP64-1:0]           Operand_a_DO,
  output logic [C_OP_FP64-1:0]           Operand_b_DO,
  output logic [C_RM-1:0]                RM_SO,
  output logic [C_FS-1:0]                Format_sel_SO,
  output logic                           Kill_SO,
  input  logic                           Unit_ready_SI,
  input  logic                           Unit_done_SI,
  input  logic [C_OP_FP64-1:0]           Unit_result_DI,
  input  logic [C_FFLAGS-1:0]            Unit_fflags_DI
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("div_sqrt_arbiter_mvp: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("div_sqrt_arbiter_mvp: TIMEOUT_CYC must be >= 1");
  end

  arb_state_e           state_SP, state_SN;
  logic [IDX_W-1:0]     ptr_SP, grant_SP;
  arb_req_t             req_SP;
  logic [C_OP_FP64-1:0] result_DP;
  logic [C_FFLAGS-1:0]  fflags_DP;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 accept, done_take, resp_hs;

  rr_arbiter_mvp #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) i_rr (
    .Valid_SI (Req_valid_SI),
    .Ptr_DI   (ptr_SP),
    .Gnt_SO   (arb_gnt),
    .Idx_DO   (arb_idx),
    .Any_SO   (arb_any)
  );

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_SP;
  logic             expired, kill, timeout_SP;

  // Counter sits at zero outside BUSY, so it is already clear on BUSY entry.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI || state_SP != ARB_BUSY) cnt_SP <= '0;
    else                                cnt_SP <= cnt_SP + 1'b1;
  end

  assign expired         = (cnt_SP == CNT_W'(TIMEOUT_CYC - 1));
  assign Kill_SO         = kill;
  assign Resp_timeout_SO = timeout_SP;
`else
  assign Kill_SO         = 1'b0;
  assign Resp_timeout_SO = 1'b0;
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state_SP <= ARB_IDLE;
    else        state_SP <= state_SN;
  end

  always_comb begin
    state_SN      = state_SP;
    Req_ready_SO  = '0;
    Resp_valid_SO = '0;
    Div_start_SO  = 1'b0;
    Sqrt_start_SO = 1'b0;
    accept        = 1'b0;
    done_take     = 1'b0;
    resp_hs       = 1'b0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    kill          = 1'b0;
`endif
    case (state_SP)
      ARB_IDLE: begin
        Req_ready_SO = arb_gnt;
        if (arb_any) begin
          accept   = 1'b1;
          state_SN = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (Unit_ready_SI) begin
          Div_start_SO  = ~req_SP.sqrt;
          Sqrt_start_SO = req_SP.sqrt;
          state_SN      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A done in the expiry cycle takes priority over the abort.
        if (Unit_done_SI) begin
          done_take = 1'b1;
          state_SN  = ARB_RESP;
        end
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        else if (expired) begin
          kill     = 1'b1;
          state_SN = ARB_RESP;
        end
`endif
      end
      ARB_RESP: begin
        Resp_valid_SO[grant_SP] = 1'b1;
        if (Resp_ready_SI[grant_SP]) begin
          resp_hs  = 1'b1;
          state_SN = ARB_IDLE;
        end
      end
      default: state_SN = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      ptr_SP    <= '0;
      grant_SP  <= '0;
      req_SP    <= '0;
      result_DP <= '0;
      fflags_DP <= '0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      timeout_SP <= 1'b0;
`endif
    end else begin
      if (accept) begin
        grant_SP    <= arb_idx;
        req_SP.sqrt <= Req_sqrt_SI[arb_idx];
        req_SP.op_a <= Req_operand_a_DI[arb_idx*C_OP_FP64 +: C_OP_FP64];
        req_SP.op_b <= Req_operand_b_DI[arb_idx*C_OP_FP64 +: C_OP_FP64];
        req_SP.rm   <= Req_rm_SI[arb_idx*C_RM +: C_RM];
        req_SP.fmt  <= Req_fmt_SI[arb_idx*C_FS +: C_FS];
      end
      if (done_take) begin
        result_DP <= Unit_result_DI;
        fflags_DP <= Unit_fflags_DI;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        timeout_SP <= 1'b0;
      end else if (kill) begin
        result_DP  <= canon_nan(req_SP.fmt);
        fflags_DP  <= C_TIMEOUT_FLAGS;
        timeout_SP <= 1'b1;
`endif
      end
      if (resp_hs)
        ptr_SP <= (grant_SP == IDX_W'(NUM_REQ - 1)) ? '0 : grant_SP + 1'b1;
    end
  end

  assign Operand_a_DO   = req_SP.op_a;
  assign Operand_b_DO   = req_SP.op_b;
  assign RM_SO          = req_SP.rm;
  assign Format_sel_SO  = req_SP.fmt;
  assign Resp_result_DO = result_DP;
  assign Resp_fflags_DO = fflags_DP;

endmodule

// File: tb/tb_div_sqrt_arbiter_mvp.sv
// Bench for div_sqrt_arbiter_mvp: directed scenarios plus randomized traffic
// against a round-robin reference model; drives a behavioural div/sqrt unit.
module tb_div_sqrt_arbiter_mvp;

  localparam int N  = 3;
  localparam int TO = 8;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic            Clk_CI = 1'b0;
  logic            Rst_RI;
  logic [N-1:0]    Req_valid_SI, Req_ready_SO, Req_sqrt_SI;
  logic [N*64-1:0] Req_operand_a_DI, Req_operand_b_DI;
  logic [N*3-1:0]  Req_rm_SI;
  logic [N*2-1:0]  Req_fmt_SI;
  logic [N-1:0]    Resp_valid_SO, Resp_ready_SI;
  logic [63:0]     Resp_result_DO, Operand_a_DO, Operand_b_DO, Unit_result_DI;
  logic [4:0]      Resp_fflags_DO, Unit_fflags_DI;
  logic            Resp_timeout_SO, Div_start_SO, Sqrt_start_SO, Kill_SO;
  logic [2:0]      RM_SO;
  logic [1:0]      Format_sel_SO;
  logic            Unit_ready_SI, Unit_done_SI;

  div_sqrt_arbiter_mvp #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
    .Req_valid_SI(Req_valid_SI), .Req_ready_SO(Req_ready_SO), .Req_sqrt_SI(Req_sqrt_SI),
    .Req_operand_a_DI(Req_operand_a_DI), .Req_operand_b_DI(Req_operand_b_DI),
    .Req_rm_SI(Req_rm_SI), .Req_fmt_SI(Req_fmt_SI),
    .Resp_valid_SO(Resp_valid_SO), .Resp_ready_SI(Resp_ready_SI),
    .Resp_result_DO(Resp_result_DO), .Resp_fflags_DO(Resp_fflags_DO),
    .Resp_timeout_SO(Resp_timeout_SO), .Div_start_SO(Div_start_SO),
    .Sqrt_start_SO(Sqrt_start_SO), .Operand_a_DO(Operand_a_DO),
    .Operand_b_DO(Operand_b_DO), .RM_SO(RM_SO), .Format_sel_SO(Format_sel_SO),
    .Kill_SO(Kill_SO), .Unit_ready_SI(Unit_ready_SI), .Unit_done_SI(Unit_done_SI),
    .Unit_result_DI(Unit_result_DI), .Unit_fflags_DI(Unit_fflags_DI)
  );

  always #5 Clk_CI = ~Clk_CI;

  int total = 0;
  int bad   = 0;

  // Reference model: pending request per requester and the round-robin pointer.
  int          ptr;
  bit          pend   [N];
  logic        p_sqrt [N];
  logic [63:0] p_a    [N];
  logic [63:0] p_b    [N];
  logic [2:0]  p_rm   [N];
  logic [1:0]  p_fmt  [N];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    if (i >= 0 && i < N) oh[i] = 1'b1;
  endfunction

  function automatic logic [63:0] ref_nan(input logic [1:0] fmt);
    case (fmt)
      2'b00:   ref_nan = 64'h7FC00000;
      2'b01:   ref_nan = 64'h7FF8000000000000;
      2'b10:   ref_nan = 64'h7E00;
      default: ref_nan = 64'h7FC0;
    endcase
  endfunction

  function automatic int pick();
    pick = -1;
    for (int k = N - 1; k >= 0; k--)
      if (pend[(ptr + k) % N]) pick = (ptr + k) % N;
  endfunction

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    p_sqrt[i] = 1'($urandom_range(0, 1));
    p_a[i]    = {$urandom, $urandom};
    p_b[i]    = {$urandom, $urandom};
    p_rm[i]   = 3'($urandom_range(0, 4));
    p_fmt[i]  = 2'($urandom_range(0, 3));
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      Req_valid_SI[i]            = pend[i];
      Req_sqrt_SI[i]             = p_sqrt[i];
      Req_operand_a_DI[i*64 +: 64] = p_a[i];
      Req_operand_b_DI[i*64 +: 64] = p_b[i];
      Req_rm_SI[i*3 +: 3]        = p_rm[i];
      Req_fmt_SI[i*2 +: 2]       = p_fmt[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(Req_ready_SO), 64'd0);
    chk({tag, "_rvalid"}, 64'(Resp_valid_SO), 64'd0);
    chk({tag, "_result"}, Resp_result_DO, 64'd0);
    chk({tag, "_misc"}, {Resp_fflags_DO, Resp_timeout_SO, Div_start_SO, Sqrt_start_SO,
                        Kill_SO, RM_SO, Format_sel_SO}, 64'd0);
    chk({tag, "_opa"}, Operand_a_DO, 64'd0);
    chk({tag, "_opb"}, Operand_b_DO, 64'd0);
  endtask

  // One full transaction: accept, issue after w not-ready cycles, done after
  // l busy cycles (or abort), response held h cycles before being taken.
  task automatic run_op(input int w, input int l, input int h, input bit do_rst,
                        input logic [63:0] res, input logic [4:0] flg, output int g);
    logic        e_sqrt;
    logic [63:0] e_a, e_b, e_res;
    logic [2:0]  e_rm;
    logic [1:0]  e_fmt;
    logic [4:0]  e_flg;
    bit          timed, exp_kill, dn;
    timed = 1'b0;
    if (pick() < 0) new_req($urandom_range(0, N - 1));
    drive_reqs();
    #1;
    g = pick();
    chk("req_ready", 64'(Req_ready_SO), 64'(oh(g)));
    e_sqrt = p_sqrt[g]; e_a = p_a[g]; e_b = p_b[g]; e_rm = p_rm[g]; e_fmt = p_fmt[g];
    tick();
    pend[g] = 1'b0;
    drive_reqs();
    for (int j = 0; j < w; j++) begin
      Unit_ready_SI = 1'b0;
      #1;
      chk("issue_wait_start", {Div_start_SO, Sqrt_start_SO}, 64'd0);
      chk("issue_wait_opa", Operand_a_DO, e_a);
      chk("issue_wait_ready", 64'(Req_ready_SO), 64'd0);
      tick();
    end
    Unit_ready_SI = 1'b1;
    #1;
    chk("start_pulse", {Div_start_SO, Sqrt_start_SO}, {!e_sqrt, e_sqrt});
    chk("issue_opa", Operand_a_DO, e_a);
    chk("issue_opb", Operand_b_DO, e_b);
    chk("issue_rm_fmt", {RM_SO, Format_sel_SO}, {e_rm, e_fmt});
    tick();
    Unit_ready_SI = 1'($urandom_range(0, 1));
    if (do_rst) begin
      Req_valid_SI = '0;
      Rst_RI = 1'b1;
      tick();
      Rst_RI = 1'b0;
      Unit_done_SI = 1'b1;
      Unit_result_DI = res;
      #1;
      check_zero("rst_busy");
      tick();
      Unit_done_SI = 1'b0;
      #1;
      chk("rst_no_resp", 64'(Resp_valid_SO), 64'd0);
      chk("rst_no_result", Resp_result_DO, 64'd0);
      ptr = 0;
      return;
    end
    for (int c = 1; c <= 40; c++) begin
      dn = (c == l + 1);
      Unit_done_SI   = dn;
      Unit_result_DI = dn ? res : {$urandom, $urandom};
      Unit_fflags_DI = dn ? flg : 5'($urandom);
      #1;
      exp_kill = TMO && (c == TO) && !dn;
      chk("busy_kill", 64'(Kill_SO), 64'(exp_kill));
      chk("busy_start", {Div_start_SO, Sqrt_start_SO}, 64'd0);
      tick();
      if (dn || exp_kill) begin
        timed = exp_kill;
        break;
      end
    end
    Unit_done_SI = 1'b0;
    e_res = timed ? ref_nan(e_fmt) : res;
    e_flg = timed ? 5'b10000 : flg;
    for (int j = 0; j <= h; j++) begin
      Resp_ready_SI    = N'($urandom);
      Resp_ready_SI[g] = (j == h);
      Unit_done_SI     = (j == 0) || ($urandom_range(0, 1) == 1);
      Unit_result_DI   = {$urandom, $urandom};
      #1;
      chk("resp_valid", 64'(Resp_valid_SO), 64'(oh(g)));
      chk("resp_result", Resp_result_DO, e_res);
      chk("resp_fflags", 64'(Resp_fflags_DO), 64'(e_flg));
      chk("resp_timeout", 64'(Resp_timeout_SO), 64'(timed));
      chk("resp_no_accept", 64'(Req_ready_SO), 64'd0);
      tick();
    end
    Resp_ready_SI = '0;
    Unit_done_SI  = 1'b0;
    ptr = (g + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    Rst_RI = 1'b1;
    Req_valid_SI = '0; Req_sqrt_SI = '0; Req_operand_a_DI = '0; Req_operand_b_DI = '0;
    Req_rm_SI = '0; Req_fmt_SI = '0; Resp_ready_SI = '0;
    Unit_ready_SI = 1'b1; Unit_done_SI = 1'b0; Unit_result_DI = '0; Unit_fflags_DI = '0;
    ptr = 0;
    clear_pend();
    tick();
    tick();
    Rst_RI = 1'b0;
    #1;
    check_zero("reset");

    // Single div from requester 0 with fixed operands.
    pend[0] = 1'b1; p_sqrt[0] = 1'b0; p_rm[0] = 3'd0; p_fmt[0] = 2'b01;
    p_a[0] = 64'h3FF0000000000000; p_b[0] = 64'h4000000000000000;
    run_op(0, 3, 0, 1'b0, 64'h3FE0000000000000, 5'b00000, g);
    chk("t1_gnt", 64'(g), 64'd0);
    clear_pend();
    new_req(1);
    run_op(0, 1, 0, 1'b0, {$urandom, $urandom}, 5'($urandom), g);

    // Two continuous requesters alternate.
    clear_pend();
    new_req(0);
    new_req(1);
    for (int k = 0; k < 4; k++) begin
      run_op($urandom_range(0, 2), $urandom_range(0, 4), 0, 1'b0,
             {$urandom, $urandom}, 5'($urandom), g);
      chk("rr_alt", 64'(g), 64'(k % 2));
      new_req(g);
    end

    // Unit not ready for 5 cycles in ISSUE.
    clear_pend();
    new_req(0);
    run_op(5, 2, 0, 1'b0, {$urandom, $urandom}, 5'($urandom), g);

    // Response to requester 1 back-pressured 10 cycles while requester 0 waits.
    new_req(0);
    new_req(1);
    run_op(0, 2, 10, 1'b0, {$urandom, $urandom}, 5'($urandom), g);
    chk("hold_gnt", 64'(g), 64'd1);

    // Reset in BUSY discards the op and returns the pointer to 0.
    clear_pend();
    new_req(1);
    run_op(0, 0, 0, 1'b1, {$urandom, $urandom}, 5'($urandom), g);
    for (int i = 0; i < N; i++) new_req(i);
    run_op(0, 1, 0, 1'b0, {$urandom, $urandom}, 5'($urandom), g);
    chk("post_rst_gnt", 64'(g), 64'd0);

    // Randomized traffic.
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if ($urandom_range(0, 3) == 0) begin
        Req_valid_SI = '0;
        #1;
        chk("idle_gap_ready", 64'(Req_ready_SO), 64'd0);
        tick();
      end
      run_op($urandom_range(0, 3), $urandom_range(0, TMO ? 12 : 6), $urandom_range(0, 3),
             1'b0, {$urandom, $urandom}, 5'($urandom), g);
    end

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    // fp32 sqrt that never completes: abort with canonical NaN.
    clear_pend();
    pend[0] = 1'b1; p_sqrt[0] = 1'b1; p_fmt[0] = 2'b00; p_rm[0] = 3'd0;
    p_a[0] = {$urandom, $urandom}; p_b[0] = {$urandom, $urandom};
    run_op(0, 30, 1, 1'b0, {$urandom, $urandom}, 5'($urandom), g);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
